// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter over valid/ready.
// Optional high-water-mark tracking is enabled by defining UART_TX_FIFO_HWM_EN.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_wr_data,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    output logic [WIDTH-1:0]       o_rd_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
`ifdef UART_TX_FIFO_HWM_EN
    input  logic                   i_hwm_clr,
    output logic [$clog2(DEPTH):0] o_hwm,
`endif
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_fire;
    logic             rd_fire;

    // Ready comes from the registered count only, so a same-cycle read never frees a slot early.
    assign o_wr_ready = i_rst_n & (count != FULL);
    assign o_rd_valid = (count != '0);
    assign o_rd_data  = mem[rd_ptr];
    assign o_count    = count;

    assign wr_fire = i_wr_valid & o_wr_ready & ~i_flush;
    assign rd_fire = o_rd_valid & i_rd_ready & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef UART_TX_FIFO_HWM_EN
    // Tracks the registered count, so the mark lags occupancy by one cycle; flush leaves it alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hwm <= '0;
        end else if (i_hwm_clr) begin
            o_hwm <= count;
        end else if (count > o_hwm) begin
            o_hwm <= count;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a byte scoreboard and occupancy model.
// High-water-mark checks are compiled in when UART_TX_FIFO_HWM_EN is defined.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CW    = 5;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b1;
    logic             i_flush = 1'b0;
    logic [WIDTH-1:0] i_wr_data = '0;
    logic             i_wr_valid = 1'b0;
    logic             o_wr_ready;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_rd_valid;
    logic             i_rd_ready = 1'b0;
    logic [CW-1:0]    o_count;
    logic             i_hwm_clr = 1'b0;
    logic [CW-1:0]    o_hwm;

    logic [7:0] q[$];
    int mcnt = 0;
    int mhwm = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (i_flush),
        .i_wr_data  (i_wr_data),
        .i_wr_valid (i_wr_valid),
        .o_wr_ready (o_wr_ready),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready),
`ifdef UART_TX_FIFO_HWM_EN
        .i_hwm_clr  (i_hwm_clr),
        .o_hwm      (o_hwm),
`endif
        .o_count    (o_count)
    );

`ifndef UART_TX_FIFO_HWM_EN
    assign o_hwm = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, check against the model, advance the model, wait one cycle.
    task automatic step(input logic wv, input logic [7:0] wd, input logic rr, input logic fl,
                        output logic acc);
        logic rf;
        i_wr_valid = wv;
        i_wr_data  = wd;
        i_rd_ready = rr;
        i_flush    = fl;
        #1;
        chk("count", 32'(o_count), 32'(mcnt));
        chk("wr_ready", 32'(o_wr_ready), 32'(mcnt != DEPTH));
        chk("rd_valid", 32'(o_rd_valid), 32'(mcnt != 0));
        if (mcnt != 0) chk("head", 32'(o_rd_data), 32'(q[0]));
`ifdef UART_TX_FIFO_HWM_EN
        chk("hwm", 32'(o_hwm), 32'(mhwm));
`endif
        acc = wv && (mcnt != DEPTH) && !fl;
        rf  = rr && (mcnt != 0) && !fl;
        if (i_hwm_clr) mhwm = mcnt;
        else if (mcnt > mhwm) mhwm = mcnt;
        if (fl) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (rf) void'(q.pop_front());
            if (acc) q.push_back(wd);
            mcnt = mcnt + int'(acc) - int'(rf);
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n    = 1'b0;
        i_wr_valid = 1'b0;
        i_rd_ready = 1'b0;
        i_flush    = 1'b0;
        i_hwm_clr  = 1'b0;
        q.delete();
        mcnt = 0;
        mhwm = 0;
        repeat (3) begin
            #1;
            chk("rst_wr_ready", 32'(o_wr_ready), 32'd0);
            chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
            chk("rst_count", 32'(o_count), 32'd0);
`ifdef UART_TX_FIFO_HWM_EN
            chk("rst_hwm", 32'(o_hwm), 32'd0);
`endif
            @(negedge i_clk);
        end
        i_rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        int sent;
        int rcvd;
        int busy;
        logic wv;
        logic rr;

        #3;
        do_reset();

        // single byte, then one read
        step(1'b1, 8'h55, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);

        // fill to full, hold 0xAA against a full FIFO, then drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, acc);
        repeat (3) begin
            step(1'b1, 8'hAA, 1'b0, 1'b0, acc);
            chk("full_reject", 32'(acc), 32'd0);
        end
        step(1'b1, 8'hAA, 1'b1, 1'b0, acc);
        chk("full_read_no_write", 32'(acc), 32'd0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, acc);
        chk("aa_accepted", 32'(acc), 32'd1);
        repeat (DEPTH) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        chk("drained_q", 32'(q.size()), 32'd0);

        // streaming through wrap-around into a transmitter that is busy for 10 bit times per byte
        sent = 0;
        rcvd = 0;
        busy = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 40 || mcnt != 0); cyc++) begin
            wv = (sent < 40) && ($urandom_range(0, 3) != 0);
            rr = (busy == 0) && ($urandom_range(0, 3) != 0);
            if (busy > 0) busy--;
            else if (rr && mcnt != 0) begin
                busy = 9;
                rcvd++;
            end
            step(wv, 8'(8'h40 + sent), rr, 1'b0, acc);
            if (acc) sent++;
        end
        chk("stream_sent", 32'(sent), 32'd40);
        chk("stream_rcvd", 32'(rcvd), 32'd40);

        // flush at count 5 alongside a write fire and a read fire
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, acc);
        step(1'b1, 8'h77, 1'b1, 1'b1, acc);
        step(1'b1, 8'h3C, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);

        // asynchronous reset in the middle of operation
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, acc);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(o_count), 32'd0);
        chk("async_rst_valid", 32'(o_rd_valid), 32'd0);
        chk("async_rst_ready", 32'(o_wr_ready), 32'd0);
        @(negedge i_clk);
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0, acc);

`ifdef UART_TX_FIFO_HWM_EN
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, acc);
        repeat (7) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("hwm_peak", 32'(o_hwm), 32'd7);
        i_hwm_clr = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        i_hwm_clr = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("hwm_clr", 32'(o_hwm), 32'd3);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("hwm_flush", 32'(o_hwm), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO directly upstream of the 8/N/1 UART transmitter.
- Absorbs bursts from the text-processing stage and presents bytes to the transmitter over a valid/ready handshake. The transmitter takes a byte when its ready is high and valid is high.
- First-word-fall-through: the head byte is always on the read data port whenever the FIFO is non-empty.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of 2 and at least 2.
- WIDTH, 8, data width in bits; the UART path uses 8.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous. Deassertion is synchronised to i_clk outside this block.
- i_flush  input  1  synchronous clear of all contents.
- i_wr_data  input  WIDTH  byte from the upstream stage.
- i_wr_valid  input  1  upstream has a byte.
- o_wr_ready  output  1  FIFO can accept a byte this cycle.
- o_rd_data  output  WIDTH  head byte; connects to the transmitter data input.
- o_rd_valid  output  1  FIFO non-empty; connects to the transmitter valid input.
- i_rd_ready  input  1  consumer takes the head byte; connects to the transmitter ready output.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Internal state:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
  - Storage array of DEPTH x WIDTH. Storage is not reset.
- Reset (i_rst_n low, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs while in reset: o_rd_valid=0, o_count=0, o_wr_ready=0 (forced low; no write is accepted in reset).
  - o_rd_data while in reset: don't-care, and the bench must not check it.
- After reset releases: o_wr_ready=1 on the first cycle.
- Handshakes:
  - Write fire = i_wr_valid & o_wr_ready.
  - Read fire = o_rd_valid & i_rd_ready.
- Combinational outputs:
  - o_wr_ready = rst released & (count != DEPTH).
  - o_rd_valid = (count != 0).
  - o_rd_data = mem[rd_ptr].
- Write fire: mem[wr_ptr] <= i_wr_data; wr_ptr <= wr_ptr+1, wrapping from DEPTH-1 to 0.
- Read fire: rd_ptr <= rd_ptr+1, wrapping.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Both in the same cycle: unchanged.
- Latency: a byte written in cycle N is visible on o_rd_data with o_rd_valid=1 in cycle N+1 when the FIFO was empty. There is no combinational path from i_wr_data to o_rd_data.
- Empty: read fire cannot occur. i_rd_ready high while empty has no effect.
- Full: o_wr_ready=0.
  - i_wr_valid is ignored; data is not lost, because upstream must hold it.
  - A read in the same cycle does not enable a write that cycle. Ready depends only on registered count. The write is accepted on the next cycle.
- Simultaneous read and write at count=1: the head advances to the new byte, count stays 1, and o_rd_valid stays high.
- i_flush:
  - Highest priority after reset. Sets wr_ptr=rd_ptr=0 and count=0 on the next edge.
  - Any write or read fire in the same cycle is discarded.
  - o_wr_ready stays combinational from count, so it may be high during a flush cycle; that write is dropped by design.
- Ordering: strict FIFO order, no duplication, no reordering across pointer wrap-around.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when the pointers are equal and the FIFO is full.
- Reset mid-operation: contents are abandoned and state returns to empty immediately (asynchronous).

Optional Feature:
- Macro: UART_TX_FIFO_HWM_EN.
- When defined:
  - Extra output port o_hwm, $clog2(DEPTH)+1 bits: the high-water mark, i.e. the maximum value count has reached since reset.
  - Updated on the cycle after count exceeds it.
  - Reset to 0 by i_rst_n. Not cleared by i_flush.
  - Extra input i_hwm_clr, synchronous, resets o_hwm to the current count.
- When undefined: neither port exists and no high-water-mark logic is generated.
- Core FIFO behaviour is identical in both builds.

Test Plan:
- Reset then idle: i_rst_n low 3 cycles -> o_wr_ready=0, o_rd_valid=0, o_count=0. After release -> o_wr_ready=1, o_rd_valid=0.
- Single byte: write 0x55 in cycle N with i_rd_ready=0 -> cycle N+1: o_rd_valid=1, o_rd_data=0x55, o_count=1. Then i_rd_ready=1 for one cycle -> o_count=0, o_rd_valid=0.
- Fill to full with DEPTH=16: write 0x00..0x0F with no reads -> o_count=16, o_wr_ready=0. A further write of 0xAA held valid is not accepted. Drain -> bytes read back 0x00..0x0F in order, then 0xAA is accepted once space exists.
- Wrap-around streaming: 40 bytes of an incrementing pattern with random i_wr_valid/i_rd_ready, plus the real transmitter model as consumer -> output sequence equals input sequence, o_count never exceeds 16, and the count invariant holds every cycle.
- Flush and concurrency: at count=5, assert i_flush together with a write fire and a read fire -> next cycle o_count=0, o_rd_valid=0. The next written byte 0x3C appears as head.
- HWM (UART_TX_FIFO_HWM_EN defined): push 7, pop 7, push 3 -> o_hwm=7. Pulse i_hwm_clr -> o_hwm=3. Assert i_flush -> o_hwm unchanged.
